// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between an instruction-fetch requester (i_*)
//   and a data requester (d_*). Data normally wins contention, but after
//   MAX_D_STREAK consecutive data grants with a fetch waiting, the fetch is
//   granted so it cannot starve.
//
//   Every transaction goes IDLE -> *_BUSY -> RESP -> IDLE. Minimum latency is
//   3 cycles. All outputs are registered.
//
//   Optional feature: define MEM_ARB_TIMEOUT_EN to abort an access after
//   TIMEOUT M_REQ cycles without m_ack. An aborted access completes with
//   data 0 and err=1. Without the macro, err is tied low and a busy state
//   waits for m_ack indefinitely.
//
// Ports
//   clk, rst           : clock; synchronous active-high reset
//   i_req/i_addr       : fetch request (held until i_rdy) and its address
//   i_rdy/i_data       : one-cycle fetch completion pulse and fetched word
//   d_req/d_wr         : data request (held until d_rdy); access code
//                        00 = read, 01 = byte store, 10 = half store,
//                        11 = word store
//   d_addr/d_wdata     : data address and store data
//   d_rdy/d_rdata      : one-cycle data completion pulse and load data
//                        (d_rdata is 0 for stores)
//   m_req/m_wr/m_addr/m_wdata : shared memory request bus
//   m_ack/m_rdata      : memory completion strobe and read data
//   stall              : arbiter busy, or a request is waiting
//   err                : pulses with the completion of an aborted access
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 2,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_rdy,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic [1:0]  d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rdy,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic [1:0]  m_wr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        stall,
  output logic        err
);

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  state_t        state;
  logic [SW-1:0] d_streak;
  logic          owner_d;   // owner of the transaction now in RESP
  logic          grant_d;
  logic          grant_i;
  logic [31:0]   rd_word;
  logic          timed_out;

  always_comb begin
    // A data request wins unless a fetch is waiting and the data streak is used up.
    grant_d = d_req && (!i_req || (d_streak != STREAK_MAX));
    grant_i = i_req && !grant_d;
    // Store completions return 0. m_wr still holds the code of the access in flight.
    rd_word = (m_wr == 2'b00) ? m_rdata : 32'h0;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;
  logic          err_r;
  // to_cnt holds the number of busy cycles already elapsed. The access
  // times out at the end of the TIMEOUT-th busy cycle.
  assign timed_out = (to_cnt == CW'(TIMEOUT - 1)) && !m_ack;
  assign err       = err_r;
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      d_streak <= '0;
      owner_d  <= 1'b0;
      i_rdy    <= 1'b0;
      i_data   <= 32'h0;
      d_rdy    <= 1'b0;
      d_rdata  <= 32'h0;
      m_req    <= 1'b0;
      m_wr     <= 2'b00;
      m_addr   <= 32'h0;
      m_wdata  <= 32'h0;
      stall    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      to_cnt   <= '0;
      err_r    <= 1'b0;
`endif
    end else begin
      // Completion strobes and their data are single-cycle.
      i_rdy   <= 1'b0;
      d_rdy   <= 1'b0;
      i_data  <= 32'h0;
      d_rdata <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_r   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= D_BUSY;
            owner_d <= 1'b1;
            m_req   <= 1'b1;
            m_wr    <= d_wr;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            stall   <= 1'b1;
            // Only grants that made a waiting fetch wait count toward the streak.
            if (i_req && (d_streak != STREAK_MAX))
              d_streak <= d_streak + 1'b1;
          end else if (grant_i) begin
            state    <= I_BUSY;
            owner_d  <= 1'b0;
            m_req    <= 1'b1;
            m_wr     <= 2'b00;
            m_addr   <= i_addr;
            m_wdata  <= 32'h0;
            stall    <= 1'b1;
            d_streak <= '0;
          end else begin
            stall <= 1'b0;
          end
        end
        I_BUSY, D_BUSY: begin
          stall <= 1'b1;
          if (m_ack || timed_out) begin
            state <= RESP;
            m_req <= 1'b0;
            if (state == D_BUSY) begin
              d_rdy   <= 1'b1;
              d_rdata <= m_ack ? rd_word : 32'h0;
            end else begin
              i_rdy  <= 1'b1;
              i_data <= m_ack ? rd_word : 32'h0;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            err_r  <= !m_ack;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          // Requests are ignored here. The owner is still holding its request
          // this cycle, so only the other side counts as waiting.
          state <= IDLE;
          stall <= owner_d ? i_req : d_req;
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_rdy;
  logic [31:0] i_data;
  logic        d_req = 1'b0;
  logic [1:0]  d_wr = 2'b00;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_rdy;
  logic [31:0] d_rdata;
  logic        m_req;
  logic [1:0]  m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic        stall;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_D_STREAK(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_data(i_data),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .stall(stall), .err(err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // Memory responder: acks after ack_delay idle M_REQ cycles (-1 = never).
  // With spur set, it drives m_ack while no request is outstanding.
  int ack_delay = 0;
  bit spur = 1'b0;
  int wcnt = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    #1;
    if (m_req === 1'b1) begin
      if (ack_delay >= 0 && wcnt == ack_delay) begin
        m_ack = 1'b1; m_rdata = mem_model(m_addr); wcnt = 0;
      end else begin
        m_ack = 1'b0; m_rdata = 32'h0; wcnt++;
      end
    end else begin
      m_ack = spur; m_rdata = spur ? 32'hBAD0BAD0 : 32'h0; wcnt = 0;
    end
  end

  task automatic test_reset();
    rst = 1'b1; d_req = 1'b1; d_addr = 32'h44;
    repeat (3) @(negedge clk);
    total++;
    if (m_req !== 1'b0 || i_rdy !== 1'b0 || d_rdy !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: m_req=%b i_rdy=%b d_rdy=%b stall=%b err=%b want all 0", m_req, i_rdy, d_rdy, stall, err);
    end
    total++;
    if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_wr !== 2'b00 || i_data !== 32'h0 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: m_addr=%h m_wdata=%h m_wr=%b i_data=%h d_rdata=%h want 0", m_addr, m_wdata, m_wr, i_data, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    exp_t e;
    sb.delete(); ack_delay = 0;
    d_req = 1'b1; d_wr = 2'b00; d_addr = 32'h100; d_wdata = 32'h0;
    sb.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
    @(negedge clk);
    total++;
    if (m_req !== 1'b1 || m_wr !== 2'b00 || m_addr !== 32'h100 || stall !== 1'b1) begin
      bad++;
      $display("FAIL load_bus: m_req=%b m_wr=%b m_addr=%h stall=%b want 1 00 00000100 1", m_req, m_wr, m_addr, stall);
    end
    @(negedge clk);
    total++;
    if (d_rdy !== 1'b1 || i_rdy !== 1'b0) begin
      bad++;
      $display("FAIL load_latency: d_rdy=%b i_rdy=%b want 1 0", d_rdy, i_rdy);
    end else begin
      e = sb.pop_front();
      total++;
      if (d_rdata !== e.data || err !== e.err) begin
        bad++;
        $display("FAIL load_data: d_rdata=%h err=%b want %h %b", d_rdata, err, e.data, e.err);
      end
    end
    d_req = 1'b0;
    @(negedge clk);
    total++;
    if (d_rdy !== 1'b0 || m_req !== 1'b0) begin
      bad++;
      $display("FAIL load_pulse: d_rdy=%b m_req=%b want 0 0", d_rdy, m_req);
    end
  endtask

  task automatic test_fetch();
    exp_t e;
    int rdy_cyc = -1;
    int pulses = 0;
    int addr_bad = 0;
    sb.delete(); ack_delay = 3;
    i_req = 1'b1; i_addr = 32'h0;
    sb.push_back('{1'b0, mem_model(32'h0), 1'b0});
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (m_req === 1'b1 && m_addr !== 32'h0) addr_bad++;
      if (c == 2) begin
        total++;
        if (stall !== 1'b1 || m_req !== 1'b1) begin
          bad++;
          $display("FAIL fetch_busy: stall=%b m_req=%b want 1 1", stall, m_req);
        end
      end
      if (d_rdy === 1'b1) pulses += 10;
      if (i_rdy === 1'b1) begin
        pulses++;
        if (rdy_cyc < 0) rdy_cyc = c;
        i_req = 1'b0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total++;
          if (i_data !== e.data || err !== e.err) begin
            bad++;
            $display("FAIL fetch_data: i_data=%h err=%b want %h %b", i_data, err, e.data, e.err);
          end
        end
      end
    end
    i_req = 1'b0;
    total++;
    if (addr_bad != 0) begin bad++; $display("FAIL fetch_addr_stable: bad_cycles=%0d want 0", addr_bad); end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL fetch_pulses: got %0d want 1", pulses); end
    total++;
    if (rdy_cyc != 5) begin bad++; $display("FAIL fetch_latency: rdy at cycle %0d want 5", rdy_cyc); end
  endtask

  task automatic test_store_ack();
    exp_t e;
    int got = 0;
    sb.delete(); ack_delay = 1;
    d_req = 1'b1; d_wr = 2'b01; d_addr = 32'h104; d_wdata = 32'h0000_00A5;
    sb.push_back('{1'b1, 32'h0, 1'b0});
    @(negedge clk);
    total++;
    if (m_req !== 1'b1 || m_wr !== 2'b01 || m_wdata !== 32'h0000_00A5 || m_addr !== 32'h104) begin
      bad++;
      $display("FAIL store_bus: m_req=%b m_wr=%b m_wdata=%h m_addr=%h want 1 01 000000a5 00000104", m_req, m_wr, m_wdata, m_addr);
    end
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk);
      if (d_rdy === 1'b1) begin
        got = 1; d_req = 1'b0;
        e = sb.pop_front();
        total++;
        if (d_rdata !== e.data || err !== e.err) begin
          bad++;
          $display("FAIL store_rdata: d_rdata=%h err=%b want %h %b", d_rdata, err, e.data, e.err);
        end
      end
    end
    d_req = 1'b0;
    total++;
    if (got != 1) begin bad++; $display("FAIL store_done: d_rdy seen=%0d want 1", got); end
    @(negedge clk);
  endtask

  task automatic test_spurious_ack();
    int errs = 0;
    sb.delete(); spur = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (m_req !== 1'b0 || i_rdy !== 1'b0 || d_rdy !== 1'b0 || stall !== 1'b0) errs++;
    end
    spur = 1'b0;
    total++;
    if (errs != 0) begin bad++; $display("FAIL spurious_ack_idle: bad_cycles=%0d want 0", errs); end
  endtask

  task automatic test_contention();
    exp_t e;
    int got = 0;
    int both = 0;
    sb.delete(); ack_delay = 0;
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_wr = 2'b00; d_addr = 32'h200; d_wdata = 32'h0;
    for (int k = 0; k < 6; k++) begin
      if (k % 3 == 2) sb.push_back('{1'b0, mem_model(32'h40), 1'b0});
      else            sb.push_back('{1'b1, mem_model(32'h200), 1'b0});
    end
    for (int c = 0; c < 80 && got < 6; c++) begin
      @(negedge clk);
      if (i_rdy === 1'b1 && d_rdy === 1'b1) both++;
      if (i_rdy === 1'b1 || d_rdy === 1'b1) begin
        got++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total++;
          if (d_rdy !== e.is_d || (e.is_d ? d_rdata : i_data) !== e.data) begin
            bad++;
            $display("FAIL contention_grant%0d: d_rdy=%b i_data=%h d_rdata=%h want is_d=%b data=%h", got, d_rdy, i_data, d_rdata, e.is_d, e.data);
          end
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    total++;
    if (got != 6) begin bad++; $display("FAIL contention_count: got %0d want 6", got); end
    total++;
    if (both != 0) begin bad++; $display("FAIL contention_exclusive: both-high cycles=%0d want 0", both); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int got = 0;
    sb.delete(); ack_delay = -1;
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_wr = 2'b00; d_addr = 32'h200;
    @(negedge clk);
    total++;
    if (m_req !== 1'b1 || m_addr !== 32'h200) begin
      bad++;
      $display("FAIL rstmid_grant: m_req=%b m_addr=%h want 1 00000200", m_req, m_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (m_req !== 1'b0 || d_rdy !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_abort: m_req=%b d_rdy=%b stall=%b want 0 0 0", m_req, d_rdy, stall);
    end
    rst = 1'b0; ack_delay = 0;
    sb.push_back('{1'b1, mem_model(32'h200), 1'b0});
    sb.push_back('{1'b1, mem_model(32'h200), 1'b0});
    sb.push_back('{1'b0, mem_model(32'h40), 1'b0});
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge clk);
      if (i_rdy === 1'b1 || d_rdy === 1'b1) begin
        got++;
        e = sb.pop_front();
        total++;
        if (d_rdy !== e.is_d || i_rdy === d_rdy) begin
          bad++;
          $display("FAIL rstmid_order%0d: d_rdy=%b i_rdy=%b want is_d=%b", got, d_rdy, i_rdy, e.is_d);
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    total++;
    if (got != 3) begin bad++; $display("FAIL rstmid_count: got %0d want 3", got); end
    @(negedge clk);
  endtask

  task automatic test_store_timeout();
    sb.delete(); ack_delay = -1;
    d_req = 1'b1; d_wr = 2'b11; d_addr = 32'h300; d_wdata = 32'h12345678;
    @(negedge clk);
    total++;
    if (m_req !== 1'b1 || m_wr !== 2'b11 || m_wdata !== 32'h12345678 || m_addr !== 32'h300) begin
      bad++;
      $display("FAIL to_bus: m_req=%b m_wr=%b m_wdata=%h m_addr=%h want 1 11 12345678 00000300", m_req, m_wr, m_wdata, m_addr);
    end
`ifdef MEM_ARB_TIMEOUT_EN
    begin
      exp_t e;
      int mreq_cyc = 1;
      bit seen = 1'b0;
      sb.push_back('{1'b1, 32'h0, 1'b1});
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        if (d_rdy === 1'b1) begin
          seen = 1'b1; d_req = 1'b0;
          e = sb.pop_front();
          total++;
          if (err !== e.err || d_rdata !== e.data || m_req !== 1'b0) begin
            bad++;
            $display("FAIL to_abort: err=%b d_rdata=%h m_req=%b want %b %h 0", err, d_rdata, m_req, e.err, e.data);
          end
        end else if (m_req === 1'b1) mreq_cyc++;
      end
      d_req = 1'b0;
      total++;
      if (!seen || mreq_cyc != 16) begin
        bad++;
        $display("FAIL to_cycles: seen=%b mreq_cycles=%0d want 1 16", seen, mreq_cyc);
      end
      @(negedge clk);
      total++;
      if (err !== 1'b0 || d_rdy !== 1'b0) begin
        bad++;
        $display("FAIL to_pulse: err=%b d_rdy=%b want 0 0", err, d_rdy);
      end
    end
`else
    begin
      int hold_bad = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (m_req !== 1'b1 || stall !== 1'b1 || d_rdy !== 1'b0 || err !== 1'b0) hold_bad++;
      end
      total++;
      if (hold_bad != 0) begin bad++; $display("FAIL to_hold: bad_cycles=%0d want 0", hold_bad); end
      d_req = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_fetch();
    test_store_ack();
    test_spurious_ack();
    test_contention();
    test_reset_mid();
    test_store_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
